// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control unit (Moore FSM).
// Decodes the IR contents (Inst) and sequences every datapath control
// strobe cycle by cycle. Memory-access states hold until MIO_ready.
// Ports:
//   clk, reset (async, active-low), MIO_ready, Inst[31:0], zero
//   IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch,
//   MemRead, MemWrite                  : 1-bit datapath controls
//   RegDst, MemtoReg, ALUSrcB, PCSource : 2-bit datapath selects
//   ALU_operation[3:0]                  : ALU function code
//   state[4:0]                          : current state code (debug)
//   err                                 : high in the absorbing ERR state
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst,
  input  logic        zero,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [3:0]  ALU_operation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [4:0]  state,
  output logic        err
);

  typedef enum logic [4:0] {
    S_IF    = 5'd0,
    S_ID    = 5'd1,
    S_MA    = 5'd2,
    S_LW_RD = 5'd3,
    S_LW_WB = 5'd4,
    S_SW_WR = 5'd5,
    S_R_EX  = 5'd6,
    S_R_WB  = 5'd7,
    S_I_EX  = 5'd8,
    S_I_WB  = 5'd9,
    S_BR    = 5'd10,
    S_J     = 5'd11,
    S_JAL   = 5'd12,
    S_JR_EX = 5'd13,
    S_JR_PC = 5'd14,
    S_LUI   = 5'd15,
    S_ERR   = 5'd31
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  state_t      state_q, state_d;
  logic [5:0]  opcode, funct;
  logic [3:0]  r_op, i_op;
  logic        r_ok;

  // zero is informational only; branch resolution lives in the datapath.
  logic unused;
  assign unused = &{1'b0, zero, Inst[25:6]};

  assign opcode = Inst[31:26];
  assign funct  = Inst[5:0];
  assign state  = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // R-type funct decode; r_ok gates the ID dispatch so bad functs trap.
  always_comb begin
    r_ok = 1'b1;
    r_op = OP_ADD;
    case (funct)
      6'b100000: r_op = OP_ADD;
      6'b100010: r_op = OP_SUB;
      6'b100100: r_op = OP_AND;
      6'b100101: r_op = OP_OR;
      6'b100110: r_op = OP_XOR;
      6'b100111: r_op = OP_NOR;
      6'b101010: r_op = OP_SLT;
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op = OP_ADD;
    case (opcode)
      6'b001010: i_op = OP_SLT;
      6'b001100: i_op = OP_AND;
      6'b001101: i_op = OP_OR;
      6'b001110: i_op = OP_XOR;
      default:   i_op = OP_ADD;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = OP_AND;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead       = 1'b1;
        ALUSrcB       = 2'b01;
        ALU_operation = OP_ADD;
        PCWrite       = 1'b1;
        IRWrite       = MIO_ready;
        if (MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        ALUSrcB       = 2'b11;
        ALU_operation = OP_ADD;
        case (opcode)
          6'b000000: begin
            if (funct == 6'b001000) state_d = S_JR_EX;
            else if (r_ok)          state_d = S_R_EX;
            else                    state_d = S_ERR;
          end
          6'b100011, 6'b101011: state_d = S_MA;
          6'b000100, 6'b000101: state_d = S_BR;
          6'b000010:            state_d = S_J;
          6'b000011:            state_d = S_JAL;
          6'b001111:            state_d = S_LUI;
          6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110:
                                state_d = S_I_EX;
          default:              state_d = S_ERR;
        endcase
      end
      S_R_EX: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_op;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_MA: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = OP_ADD;
        state_d       = (opcode == 6'b101011) ? S_SW_WR : S_LW_RD;
      end
      S_LW_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MIO_ready) state_d = S_LW_WB;
      end
      S_LW_WB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_SW_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MIO_ready) state_d = S_IF;
      end
      S_I_EX: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = i_op;
        state_d       = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = OP_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        Branch        = (opcode == 6'b000100);
        state_d       = S_IF;
      end
      S_J: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = S_IF;
      end
      S_JAL: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_LUI: begin
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_JR_EX: begin
        ALUSrcA       = 1'b1;
        ALU_operation = OP_ADD;
        state_d       = S_JR_PC;
      end
      S_JR_PC: begin
        PCSource = 2'b11;
        PCWrite  = 1'b1;
        state_d  = S_IF;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: state_d = S_ERR;
    endcase
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle MIPS control unit sitting directly upstream of the multi-cycle datapath: it decodes the instruction register contents and the ALU `zero` flag, then drives every datapath control input cycle by cycle. It is a Moore-style FSM, except that memory-access strobes are held until `MIO_ready`. It is the sole source of `IorD`, `IRWrite`, `RegDst`, `RegWrite`, `MemtoReg`, `ALUSrcA`, `ALUSrcB`, `PCSource`, `PCWrite`, `PCWriteCond`, `Branch`, `ALU_operation`, `MemRead` and `MemWrite`.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; forces state to IF.
- `MIO_ready` in 1: memory/IO transfer complete this cycle.
- `Inst` in 32: IR contents from datapath.
- `zero` in 1: ALU zero flag (informational; branch resolution happens in datapath via `Branch`).
- `IorD`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCWrite`, `PCWriteCond`, `Branch`, `MemRead`, `MemWrite` out 1 each.
- `RegDst`, `MemtoReg`, `ALUSrcB`, `PCSource` out 2 each.
- `ALU_operation` out 4: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111.
- `state` out 5: current state code (debug).
- `err` out 1: high in ERR.

## Operation
- State codes: IF 0, ID 1, MA 2, LW_RD 3, LW_WB 4, SW_WR 5, R_EX 6, R_WB 7, I_EX 8, I_WB 9, BR 10, J 11, JAL 12, JR_EX 13, JR_PC 14, LUI 15, ERR 31.
- Every control output not listed for a state is 0.
- **IF**: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, ADD, `PCSource`=00, `PCWrite`=1. `IRWrite`=`MIO_ready`. Stay in IF until `MIO_ready`, then go to ID.
- **ID**: `ALUSrcA`=0, `ALUSrcB`=11, ADD, so ALUOut captures the branch target. Dispatch on `Inst[31:26]`:
  - 000000 with funct 001000 (jr) → JR_EX; other supported functs → R_EX.
  - 100011/101011 (lw/sw) → MA.
  - 000100/000101 (beq/bne) → BR.
  - 000010 (j) → J; 000011 (jal) → JAL; 001111 (lui) → LUI.
  - 001000/001010/001100/001101/001110 (addi/slti/andi/ori/xori) → I_EX.
  - Anything else → ERR.
- **R funct → ALU op**: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT. Any other funct → ERR.
- **R_EX**: `ALUSrcA`=1, `ALUSrcB`=00, op from funct. → R_WB.
- **R_WB**: `RegDst`=01, `MemtoReg`=00, `RegWrite`=1. → IF.
- **MA**: `ALUSrcA`=1, `ALUSrcB`=10, ADD. → LW_RD (lw) or SW_WR (sw).
- **LW_RD**: `IorD`=1, `MemRead`=1. Hold until `MIO_ready`, then → LW_WB.
- **LW_WB**: `RegDst`=00, `MemtoReg`=01, `RegWrite`=1. → IF.
- **SW_WR**: `IorD`=1, `MemWrite`=1. Hold until `MIO_ready`, then → IF.
- **I_EX**: `ALUSrcA`=1, `ALUSrcB`=10. Op: addi ADD, slti SLT, andi AND, ori OR, xori XOR. → I_WB.
  - Immediate is sign-extended by the datapath for all of these, including andi/ori/xori; this is accepted behaviour.
- **I_WB**: `RegDst`=00, `MemtoReg`=00, `RegWrite`=1. → IF.
- **BR**: `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCWriteCond`=1, `PCSource`=01. `Branch`=1 for beq, 0 for bne. → IF.
- **J**: `PCSource`=10, `PCWrite`=1. → IF.
- **JAL**: as J, plus `RegDst`=10, `MemtoReg`=11, `RegWrite`=1. The PC already holds PC+4, so $31 receives the return address. → IF.
- **LUI**: `RegDst`=00, `MemtoReg`=10, `RegWrite`=1. → IF.
- **JR_EX**: `ALUSrcA`=1, `ALUSrcB`=00, ADD. rt is $0, so ALUOut = rs. → JR_PC.
- **JR_PC**: `PCSource`=11, `PCWrite`=1. → IF.
- **ERR**: all controls 0, `err`=1. Absorbing until `reset` asserts.

## Timing
- State register updates on the rising edge of `clk`; `reset` low clears it to IF immediately, asynchronously.
- Outputs are combinational from state, plus `MIO_ready` for `IRWrite` only.
- While in reset: `state`=0, `err`=0, and controls show the IF pattern (`MemRead`=1, `PCWrite`=1, `ALUSrcB`=01, `ALU_operation`=0010, `IRWrite`=`MIO_ready`, all others 0).
- Cycle counts with zero wait states:

| Instruction | Cycles |
|---|---|
| R-type | 4 |
| I-ALU | 4 |
| lw | 5 |
| sw | 4 |
| beq/bne | 3 |
| j, jal | 3 |
| lui | 3 |
| jr | 4 |

- Each cycle with `MIO_ready`=0 in IF, LW_RD or SW_WR adds one cycle.
  - IR is not written while stalled in IF.
  - The datapath's PC write is gated by `MIO_ready`.
- Reset asserted mid-instruction: any pending register or memory write is abandoned. The first fetch happens after reset releases.
- `Inst` is sampled only in ID and later states. It is stable from the IF exit until the next IF.

## Test plan
- **R-type add**: `Inst`=0x00221820, `MIO_ready`=1 → states 0,1,6,7,0. `ALU_operation`=0010 in state 6; `RegDst`=01 and `RegWrite`=1 in state 7.
- **lw with wait states**: `Inst`=0x8C410004, `MIO_ready` low for 2 cycles in LW_RD → state 3 held for 3 cycles. `MemRead`=1 and `IorD`=1 throughout, then LW_WB with `MemtoReg`=01.
- **bne**: `Inst`=0x1422FFFF → BR shows `Branch`=0, `PCWriteCond`=1, `PCSource`=01, `ALU_operation`=0110. Back in IF next cycle.
- **jal**: `Inst`=0x0C000010 → JAL shows `RegDst`=10, `MemtoReg`=11, `RegWrite`=1, `PCSource`=10, `PCWrite`=1. Total 3 cycles.
- **jr**: `Inst`=0x03E00008 → states 0,1,13,14. `PCSource`=11 and `PCWrite`=1 in state 14.
- **Illegal, then reset**: opcode 0x3F → `state`=31, `err`=1, and all controls 0 indefinitely. Pulse `reset` low mid-cycle → `state`=0 immediately, `err`=0.
